mdu: RTL

Multiply/divide unit on the execute stage, beside the ALU. It consumes the same two operands the ALU sees: `data1` from register read port 1 and `data2` from the operand-B select (register or extended immediate). It runs `mult`/`multu`/`div`/`divu` as fixed-latency multi-cycle operations into HI/LO, and serves `mthi`/`mtlo` in one cycle. While an operation is in flight it asserts `busy` so the hazard unit can stall any dependent `mf*`/`mt*`/`md` instruction.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_if.sv | 13 +
 rtl/mdu_calc.sv | 51 +++++
 rtl/mdu.sv | 102 ++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared CPU defines for the multiply/divide unit: op encodings, default
// latencies and the MDU FSM state type.
package mdu_pkg;

  typedef enum logic [2:0] {
    MduNone  = 3'd0,
    MduMult  = 3'd1,
    MduMultu = 3'd2,
    MduDiv   = 3'd3,
    MduDivu  = 3'd4,
    MduMthi  = 3'd5,
    MduMtlo  = 3'd6,
    MduRsvd  = 3'd7
  } mdu_op_e;

  typedef enum logic {StIdle, StRun} mdu_state_e;

  localparam int unsigned MultCyclesDefault = 5;
  localparam int unsigned DivCyclesDefault  = 10;

  function automatic logic is_md_op(mdu_op_e op);
    return (op == MduMult) || (op == MduMultu) || (op == MduDiv) || (op == MduDivu);
  endfunction

  function automatic logic is_div_op(mdu_op_e op);
    return (op == MduDiv) || (op == MduDivu);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Execute-stage operand/result bundle between the pipeline and the MDU.
interface mdu_if;
  logic        start;
  logic [2:0]  MDU_op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, MDU_op, data1, data2, input busy, HI, LO);
  modport slave  (input start, MDU_op, data1, data2, output busy, HI, LO);
endinterface

// File: rtl/mdu_calc.sv
// Combinational 32x32 multiply/divide datapath producing {hi, lo}.
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic [63:0] result_o,
  output logic        div_zero_o
);

  logic               zero_divisor;
  logic        [31:0] divisor;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  // A safe divisor keeps the datapath X-free; the result is discarded on /0.
  assign zero_divisor = (data2_i == 32'h0);
  assign divisor      = zero_divisor ? 32'h1 : data2_i;
  assign div_zero_o   = zero_divisor && is_div_op(op_i);

  assign prod_s = $signed({{32{data1_i[31]}}, data1_i}) * $signed({{32{data2_i[31]}}, data2_i});
  assign prod_u = {32'h0, data1_i} * {32'h0, data2_i};
  assign quo_s  = $signed(data1_i) / $signed(divisor);
  assign rem_s  = $signed(data1_i) % $signed(divisor);
  assign quo_u  = data1_i / divisor;
  assign rem_u  = data1_i % divisor;

  always_comb begin
    result_o = 64'h0;
    case (op_i)
      MduMult:  result_o = prod_s;
      MduMultu: result_o = prod_u;
      MduDiv: begin
        // INT_MIN / -1 overflows; pin it to the wrapped quotient explicitly.
        if (data1_i == 32'h8000_0000 && data2_i == 32'hFFFF_FFFF) begin
          result_o = {32'h0, 32'h8000_0000};
        end else begin
          result_o = {rem_s, quo_s};
        end
      end
      MduDivu:  result_o = {rem_u, quo_u};
      default:  result_o = 64'h0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency md ops into HI/LO, single-cycle mthi/mtlo.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDefault,
  parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_op_e          op;
  logic [63:0]      calc_res;
  logic             calc_div_zero;

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_dz_q, pend_dz_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  assign op = mdu_op_e'(bus.MDU_op);

  mdu_calc u_calc (
    .op_i       (op),
    .data1_i    (bus.data1),
    .data2_i    (bus.data2),
    .result_o   (calc_res),
    .div_zero_o (calc_div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_dz_d = pend_dz_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (is_md_op(op)) begin
            state_d   = StRun;
            busy_d    = 1'b1;
            pend_d    = calc_res;
            pend_dz_d = calc_div_zero;
            cnt_d     = is_div_op(op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
          end else if (op == MduMthi) begin
            hi_d = bus.data1;
          end else if (op == MduMtlo) begin
            lo_d = bus.data1;
          end
        end
      end
      StRun: begin
        // Any start seen here is dropped; the hazard unit owns stalling it.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          if (!pend_dz_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_dz_q <= pend_dz_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
